sonar_scan_uc: RTL and testbench
================================

SONAR_SCAN_UC -- requirements
Module: sonar_scan_uc

Interface
REQ-001 Parameter N_DIGITS, default 4, number of characters sent per measurement (≥1).
REQ-002 Parameter N_POS, default 8, number of servo positions per sweep (≥2).
REQ-003 Parameter INTERVAL_CYCLES, default 50000000, clock cycles spent waiting between positions (≥1).
REQ-004 Parameter TIMEOUT_CYCLES, default 2000000, maximum clock cycles spent waiting for fim_medida (≥1).
REQ-005 Local widths: DW = max(1, clog2(N_DIGITS)); PW = max(1, clog2(N_POS)).
REQ-006 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-007 clock  in  1  system clock.
REQ-008 reset  in  1  asynchronous reset, active-high.
REQ-009 ligar  in  1  level; enables scanning.
REQ-010 modo  in  1  0 = continuous back-and-forth sweep, 1 = single sweep 0..N_POS-1; sampled in INICIAL only.
REQ-011 fim_medida  in  1  one-cycle pulse from the measurement datapath.
REQ-012 fim_transmissao  in  1  one-cycle pulse from the serial transmitter.
REQ-013 zera  out  1  clears the datapath.
REQ-014 medir_distancia  out  1  one-cycle measurement start pulse.
REQ-015 transmitir  out  1  one-cycle character transmit pulse.
REQ-016 digito  out  DW  index of the current character.
REQ-017 posicao  out  PW  current servo position.
REQ-018 direcao  out  1  0 = counting up, 1 = counting down.
REQ-019 erro  out  1  sticky measurement-timeout flag.
REQ-020 pronto  out  1  single sweep complete.
REQ-021 db_estado  out  4  state code.

Function
REQ-022 States and codes: INICIAL 0, PREPARACAO 1, MEDIR 2, ESPERA_MEDIDA 3, TRANSMISSAO 4, ESPERA_TRANSMISSAO 5, PROXIMO_DIGITO 6, PROXIMA_POSICAO 7, ESPERA_INTERVALO 8, TIMEOUT 9, FIM A.
- db_estado SHALL show the code of the current state.
- Any unused encoding SHALL show F on db_estado and SHALL go to INICIAL on the next cycle.
REQ-023 State transitions:
- INICIAL → PREPARACAO when ligar=1.
- PREPARACAO → MEDIR.
- MEDIR → ESPERA_MEDIDA.
REQ-024 ESPERA_MEDIDA:
- On fim_medida=1, go to TRANSMISSAO.
- Otherwise, when the timeout counter = TIMEOUT_CYCLES-1, go to TIMEOUT.
- If both occur in the same cycle, fim_medida wins.
REQ-025 TRANSMISSAO → ESPERA_TRANSMISSAO.
REQ-026 ESPERA_TRANSMISSAO, on fim_transmissao=1:
- If digito = N_DIGITS-1, go to PROXIMA_POSICAO.
- Otherwise, go to PROXIMO_DIGITO.
REQ-027 PROXIMO_DIGITO SHALL increment digito and go to TRANSMISSAO.
REQ-028 TIMEOUT SHALL set erro and go to PROXIMA_POSICAO; no characters are transmitted for that position.
REQ-029 PROXIMA_POSICAO:
- Single mode with posicao = N_POS-1: go to FIM, posicao unchanged.
- Otherwise: update posicao per REQ-030 and go to ESPERA_INTERVALO.
REQ-030 Position update (bounce):
- Up direction: posicao+1. At N_POS-1, set direcao=1 and posicao = N_POS-2.
- Down direction: posicao-1. At 0, set direcao=0 and posicao = 1.
- posicao never wraps.
REQ-031 ESPERA_INTERVALO SHALL count INTERVAL_CYCLES cycles, then:
- If ligar=1, go to PREPARACAO.
- If ligar=0, go to INICIAL.
REQ-032 FIM SHALL hold pronto=1 and go to INICIAL when ligar=0.
REQ-033 Moore outputs:
- zera=1 in INICIAL and PREPARACAO.
- medir_distancia=1 in MEDIR only.
- transmitir=1 in TRANSMISSAO only.
REQ-034 Counter clearing:
- PREPARACAO SHALL clear digito, the timeout counter and the interval counter.
- INICIAL SHALL also clear posicao and direcao.
REQ-035 erro SHALL be cleared only by reset or on the INICIAL→PREPARACAO transition.
REQ-036 The timeout counter SHALL count only in ESPERA_MEDIDA. The interval counter SHALL count only in ESPERA_INTERVALO.
REQ-037 Pulses on fim_medida or fim_transmissao outside their wait states SHALL be ignored.

Reset
REQ-038 Asserting reset at any time, including mid-transmission, SHALL within the same cycle force:
- state INICIAL;
- digito=0, posicao=0, direcao=0, erro=0, pronto=0;
- medir_distancia=0, transmitir=0, zera=1, db_estado=0.
REQ-039 After reset release, the block SHALL remain in INICIAL until ligar=1.

Verification (N_DIGITS=3, N_POS=4, INTERVAL_CYCLES=10, TIMEOUT_CYCLES=20)
REQ-040 Continuous mode, ligar=1, fim_medida 5 cycles after each medir_distancia, fim_transmissao 3 cycles after each transmitir → 3 transmitir pulses per position; posicao sequence 0,1,2,3,2,1,0,1; ESPERA_INTERVALO lasts exactly 10 cycles.
REQ-041 fim_medida withheld → TIMEOUT entered exactly 20 cycles after entering ESPERA_MEDIDA; erro=1; no transmitir pulse; posicao advances; erro stays 1 through later good measurements.
REQ-042 fim_medida asserted on the 20th ESPERA_MEDIDA cycle → TRANSMISSAO taken, erro stays 0.
REQ-043 modo=1 → positions 0..3 measured once; FIM (db_estado A) with pronto=1; ligar=0 → INICIAL, pronto=0; ligar=1 again → erro cleared, posicao restarts at 0.
REQ-044 ligar dropped during ESPERA_TRANSMISSAO → remaining characters still sent; INICIAL reached after ESPERA_INTERVALO; posicao=0.
REQ-045 reset pulsed in ESPERA_TRANSMISSAO at digito=1, posicao=2 → all outputs at their REQ-038 values in the same cycle; extra fim_transmissao pulses ignored.

Source files
------------

// File: rtl/sonar_scan_uc.sv
// Sonar scan control unit: sweeps the servo over N_POS positions, triggers a
// measurement at each one and streams N_DIGITS characters of the result.
module sonar_scan_uc #(
   parameter int N_DIGITS        = 4,
   parameter int N_POS           = 8,
   parameter int INTERVAL_CYCLES = 50000000,
   parameter int TIMEOUT_CYCLES  = 2000000,
   localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
   localparam int PW = (N_POS > 1) ? $clog2(N_POS) : 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          ligar,
   input  logic          modo,
   input  logic          fim_medida,
   input  logic          fim_transmissao,
   output logic          zera,
   output logic          medir_distancia,
   output logic          transmitir,
   output logic [DW-1:0] digito,
   output logic [PW-1:0] posicao,
   output logic          direcao,
   output logic          erro,
   output logic          pronto,
   output logic [3:0]    db_estado
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int IW = (INTERVAL_CYCLES > 1) ? $clog2(INTERVAL_CYCLES) : 1;

   localparam logic [3:0] INICIAL            = 4'h0;
   localparam logic [3:0] PREPARACAO         = 4'h1;
   localparam logic [3:0] MEDIR              = 4'h2;
   localparam logic [3:0] ESPERA_MEDIDA      = 4'h3;
   localparam logic [3:0] TRANSMISSAO        = 4'h4;
   localparam logic [3:0] ESPERA_TRANSMISSAO = 4'h5;
   localparam logic [3:0] PROXIMO_DIGITO     = 4'h6;
   localparam logic [3:0] PROXIMA_POSICAO    = 4'h7;
   localparam logic [3:0] ESPERA_INTERVALO   = 4'h8;
   localparam logic [3:0] TIMEOUT            = 4'h9;
   localparam logic [3:0] FIM                = 4'hA;

   localparam logic [DW-1:0] DIG_LAST = DW'(N_DIGITS - 1);
   localparam logic [PW-1:0] POS_LAST = PW'(N_POS - 1);
   localparam logic [PW-1:0] POS_PEN  = PW'(N_POS - 2);
   localparam logic [PW-1:0] POS_ONE  = PW'(1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [IW-1:0] INT_LAST = IW'(INTERVAL_CYCLES - 1);

   logic [3:0]    state, state_n;
   logic [TW-1:0] tmo_cnt;
   logic [IW-1:0] int_cnt;
   logic          modo_r;
   logic          sweep_done;

   assign sweep_done = modo_r && (posicao == POS_LAST);

   always_comb begin
      state_n = state;
      case (state)
         INICIAL:            if (ligar) state_n = PREPARACAO;
         PREPARACAO:         state_n = MEDIR;
         MEDIR:              state_n = ESPERA_MEDIDA;
         ESPERA_MEDIDA: begin
            // a result arriving on the last allowed cycle beats the timeout
            if (fim_medida)               state_n = TRANSMISSAO;
            else if (tmo_cnt == TMO_LAST) state_n = TIMEOUT;
         end
         TRANSMISSAO:        state_n = ESPERA_TRANSMISSAO;
         ESPERA_TRANSMISSAO: begin
            if (fim_transmissao)
               state_n = (digito == DIG_LAST) ? PROXIMA_POSICAO : PROXIMO_DIGITO;
         end
         PROXIMO_DIGITO:     state_n = TRANSMISSAO;
         PROXIMA_POSICAO:    state_n = sweep_done ? FIM : ESPERA_INTERVALO;
         ESPERA_INTERVALO: begin
            if (int_cnt == INT_LAST) state_n = ligar ? PREPARACAO : INICIAL;
         end
         TIMEOUT:            state_n = PROXIMA_POSICAO;
         FIM:                if (!ligar) state_n = INICIAL;
         default:            state_n = INICIAL;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= INICIAL;
         tmo_cnt <= '0;
         int_cnt <= '0;
         digito  <= '0;
         posicao <= '0;
         direcao <= 1'b0;
         erro    <= 1'b0;
         modo_r  <= 1'b0;
      end else begin
         state <= state_n;

         tmo_cnt <= (state == ESPERA_MEDIDA) ? tmo_cnt + 1'b1 : '0;
         int_cnt <= (state == ESPERA_INTERVALO) ? int_cnt + 1'b1 : '0;

         if (state == INICIAL) begin
            modo_r  <= modo;
            digito  <= '0;
            posicao <= '0;
            direcao <= 1'b0;
            if (ligar) erro <= 1'b0;
         end

         if (state == PREPARACAO)     digito <= '0;
         if (state == PROXIMO_DIGITO) digito <= digito + 1'b1;
         if (state == TIMEOUT)        erro   <= 1'b1;

         // bounce at both ends so the servo never jumps across the sweep
         if (state == PROXIMA_POSICAO && !sweep_done) begin
            if (!direcao) begin
               if (posicao == POS_LAST) begin
                  direcao <= 1'b1;
                  posicao <= POS_PEN;
               end else begin
                  posicao <= posicao + 1'b1;
               end
            end else begin
               if (posicao == '0) begin
                  direcao <= 1'b0;
                  posicao <= POS_ONE;
               end else begin
                  posicao <= posicao - 1'b1;
               end
            end
         end
      end
   end

   assign zera            = (state == INICIAL) || (state == PREPARACAO);
   assign medir_distancia = (state == MEDIR);
   assign transmitir      = (state == TRANSMISSAO);
   assign pronto          = (state == FIM);
   assign db_estado       = (state <= FIM) ? state : 4'hF;

endmodule

// File: tb/tb_sonar_scan_uc.sv
// Directed bench for sonar_scan_uc: a per-cycle vector table for the first
// position, then hand-written sequences for sweep, timeout, single mode and reset.
module tb_sonar_scan_uc;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       ligar = 1'b0;
   logic       modo = 1'b0;
   logic       fim_medida = 1'b0;
   logic       fim_transmissao = 1'b0;
   logic       zera, medir_distancia, transmitir, direcao, erro, pronto;
   logic [1:0] digito;
   logic [1:0] posicao;
   logic [3:0] db_estado;

   sonar_scan_uc #(
      .N_DIGITS(3), .N_POS(4), .INTERVAL_CYCLES(10), .TIMEOUT_CYCLES(20)
   ) dut (
      .clock(clock), .reset(reset), .ligar(ligar), .modo(modo),
      .fim_medida(fim_medida), .fim_transmissao(fim_transmissao),
      .zera(zera), .medir_distancia(medir_distancia), .transmitir(transmitir),
      .digito(digito), .posicao(posicao), .direcao(direcao), .erro(erro),
      .pronto(pronto), .db_estado(db_estado)
   );

   initial forever #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic       ligar, fm, ft;
      logic [3:0] st;
      logic [1:0] dig, pos;
      logic       tx, med;
   } vec_t;

   vec_t vt[$];
   int   checks = 0;
   int   errors = 0;

   // responder / trackers
   bit   resp_en = 0;
   bit   med_withhold = 0;
   int   med_cnt = 0, tx_cnt = 0;
   int   tx_count = 0;
   int   ei_run = 0;
   int   pos_log[$];
   int   ei_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic l, input logic fm, input logic ft, input logic [3:0] st,
                      input int dig, input int pos, input logic tx, input logic med);
      vec_t v;
      v.ligar = l; v.fm = fm; v.ft = ft; v.st = st;
      v.dig = 2'(dig); v.pos = 2'(pos); v.tx = tx; v.med = med;
      vt.push_back(v);
   endtask

   task automatic clear_trk();
      tx_count = 0; ei_run = 0; med_cnt = 0; tx_cnt = 0;
      pos_log.delete(); ei_log.delete();
   endtask

   task automatic tick();
      @(posedge clock); #1;
      if (transmitir) tx_count++;
      if (db_estado == 4'h2) pos_log.push_back(int'(posicao));
      if (db_estado == 4'h8) ei_run++;
      else if (ei_run != 0) begin ei_log.push_back(ei_run); ei_run = 0; end
      if (resp_en) begin
         fim_medida = 1'b0;
         fim_transmissao = 1'b0;
         if (med_cnt > 0) begin med_cnt--; if (med_cnt == 0) fim_medida = 1'b1; end
         if (tx_cnt > 0) begin tx_cnt--; if (tx_cnt == 0) fim_transmissao = 1'b1; end
         if (medir_distancia && !med_withhold) med_cnt = 5;
         if (transmitir) tx_cnt = 3;
      end
   endtask

   task automatic wait_state(input logic [3:0] code, input int budget, input string name);
      int n = 0;
      while (db_estado != code && n < budget) begin tick(); n++; end
      chk({name, "_reached"}, db_estado, code);
   endtask

   task automatic do_reset();
      resp_en = 0; med_withhold = 0;
      ligar = 0; modo = 0; fim_medida = 0; fim_transmissao = 0;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      clear_trk();
   endtask

   initial begin
      int n;
      int exp_sweep[8] = '{0, 1, 2, 3, 2, 1, 0, 1};

      #3;
      chk("por_state", db_estado, 4'h0);
      chk("por_zera", zera, 1'b1);
      chk("por_pronto", pronto, 1'b0);

      // first position, one vector per clock
      add(0,0,0, 4'h0, 0,0, 0,0);
      add(1,0,0, 4'h1, 0,0, 0,0);
      add(1,0,0, 4'h2, 0,0, 0,1);
      add(1,0,0, 4'h3, 0,0, 0,0);
      add(1,0,1, 4'h3, 0,0, 0,0);
      add(1,1,0, 4'h4, 0,0, 1,0);
      add(1,0,0, 4'h5, 0,0, 0,0);
      add(1,1,0, 4'h5, 0,0, 0,0);
      add(1,0,1, 4'h6, 0,0, 0,0);
      add(1,0,0, 4'h4, 1,0, 1,0);
      add(1,0,0, 4'h5, 1,0, 0,0);
      add(1,0,1, 4'h6, 1,0, 0,0);
      add(1,0,0, 4'h4, 2,0, 1,0);
      add(1,0,0, 4'h5, 2,0, 0,0);
      add(1,0,1, 4'h7, 2,0, 0,0);
      for (int i = 0; i < 10; i++) add(1,0,0, 4'h8, 2,1, 0,0);
      add(1,0,0, 4'h1, 2,1, 0,0);
      add(1,0,0, 4'h2, 0,1, 0,1);

      do_reset();
      for (int i = 0; i < vt.size(); i++) begin
         ligar = vt[i].ligar; fim_medida = vt[i].fm; fim_transmissao = vt[i].ft;
         tick();
         chk($sformatf("vec%0d_state", i), db_estado, vt[i].st);
         chk($sformatf("vec%0d_dig_pos_tx_med", i),
             {digito, posicao, transmitir, medir_distancia},
             {vt[i].dig, vt[i].pos, vt[i].tx, vt[i].med});
      end
      fim_medida = 0; fim_transmissao = 0;

      // continuous sweep with a well-behaved datapath
      do_reset();
      ligar = 1; resp_en = 1;
      n = 0;
      while (pos_log.size() < 8 && n < 3000) begin tick(); n++; end
      chk("sweep_positions", pos_log.size(), 8);
      chk("sweep_tx_count", tx_count, 21);
      for (int i = 0; i < 8 && i < pos_log.size(); i++)
         chk($sformatf("sweep_pos%0d", i), pos_log[i], exp_sweep[i]);
      chk("sweep_ei_runs", ei_log.size(), 7);
      for (int i = 0; i < ei_log.size(); i++)
         chk($sformatf("sweep_ei_len%0d", i), ei_log[i], 10);

      // measurement timeout
      do_reset();
      ligar = 1; resp_en = 1; med_withhold = 1;
      wait_state(4'h3, 50, "tmo_wait_em");
      n = 0;
      while (db_estado != 4'h9 && n < 100) begin tick(); n++; end
      chk("tmo_latency", n, 20);
      tick();
      chk("tmo_erro_set", erro, 1'b1);
      wait_state(4'h8, 10, "tmo_to_ei");
      chk("tmo_pos_advance", posicao, 2'd1);
      chk("tmo_no_tx", tx_count, 0);
      med_withhold = 0;
      wait_state(4'h7, 300, "tmo_next_pos");
      chk("tmo_later_tx", tx_count, 3);
      chk("tmo_erro_sticky", erro, 1'b1);

      // fim_medida on the last allowed cycle
      do_reset();
      ligar = 1;
      wait_state(4'h3, 10, "late_wait_em");
      repeat (19) tick();
      chk("late_still_em", db_estado, 4'h3);
      fim_medida = 1; tick(); fim_medida = 0;
      chk("late_tx_state", db_estado, 4'h4);
      chk("late_erro", erro, 1'b0);

      // single sweep with a timeout on position 0
      do_reset();
      modo = 1; ligar = 1; resp_en = 1; med_withhold = 1;
      n = 0;
      while (db_estado != 4'hA && n < 3000) begin
         tick(); n++;
         if (db_estado == 4'h9) med_withhold = 0;
      end
      chk("single_fim", db_estado, 4'hA);
      chk("single_pronto", pronto, 1'b1);
      chk("single_pos", posicao, 2'd3);
      chk("single_erro", erro, 1'b1);
      chk("single_positions", pos_log.size(), 4);
      for (int i = 0; i < 4 && i < pos_log.size(); i++)
         chk($sformatf("single_pos%0d", i), pos_log[i], i);
      chk("single_tx_count", tx_count, 9);
      resp_en = 0; modo = 0; ligar = 0;
      tick();
      chk("single_off_state", db_estado, 4'h0);
      chk("single_off_pronto", pronto, 1'b0);
      ligar = 1;
      tick();
      chk("single_restart_state", db_estado, 4'h1);
      chk("single_restart_erro", erro, 1'b0);
      chk("single_restart_pos", posicao, 2'd0);

      // ligar dropped mid-transmission
      do_reset();
      ligar = 1; resp_en = 1;
      wait_state(4'h5, 50, "drop_wait_et");
      ligar = 0;
      wait_state(4'h0, 300, "drop_inicial");
      chk("drop_tx_count", tx_count, 3);
      chk("drop_ei_len", (ei_log.size() == 1) ? ei_log[0] : -1, 10);
      tick();
      chk("drop_pos", posicao, 2'd0);
      chk("drop_stay", db_estado, 4'h0);

      // asynchronous reset in the middle of a transmission
      do_reset();
      ligar = 1; resp_en = 1;
      n = 0;
      while (!(db_estado == 4'h5 && digito == 2'd1 && posicao == 2'd2 && direcao) && n < 3000) begin
         tick(); n++;
      end
      chk("rst_setup", {db_estado, digito, posicao, direcao}, {4'h5, 2'd1, 2'd2, 1'b1});
      resp_en = 0; fim_medida = 0; fim_transmissao = 0;
      #2 reset = 1'b1;
      #1;
      chk("rst_state", db_estado, 4'h0);
      chk("rst_dig_pos_dir", {digito, posicao, direcao}, 5'd0);
      chk("rst_erro_pronto", {erro, pronto}, 2'b00);
      chk("rst_pulses", {medir_distancia, transmitir}, 2'b00);
      chk("rst_zera", zera, 1'b1);
      tick();
      reset = 1'b0; ligar = 0;
      for (int i = 0; i < 3; i++) begin
         fim_transmissao = 1; tick();
         fim_transmissao = 0; tick();
      end
      chk("rst_ignore_ft_state", db_estado, 4'h0);
      chk("rst_ignore_ft_dig", digito, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
